// File: rtl/vec_log_pkg.sv
// Shared record layout and defaults for the vector logger.
// Records are {err, i[3:0], s[1:0], y}.
package vec_log_pkg;

  localparam int REC_W     = 8;
  localparam int ERR_BIT   = 7;
  localparam int I_MSB     = 6;
  localparam int I_LSB     = 3;
  localparam int S_MSB     = 2;
  localparam int S_LSB     = 1;
  localparam int Y_BIT     = 0;
  localparam int CNT_W_DEF = 16;

  function automatic logic [REC_W-1:0] pack_rec(
    input logic       err,
    input logic [3:0] i,
    input logic [1:0] s,
    input logic       y
  );
    logic [REC_W-1:0] r;
    r                = '0;
    r[ERR_BIT]       = err;
    r[I_MSB:I_LSB]   = i;
    r[S_MSB:S_LSB]   = s;
    r[Y_BIT]         = y;
    return r;
  endfunction

endpackage

// File: rtl/vec_log_fifo.sv
// First-word-fall-through FIFO with flush.
// Pointers carry one extra bit to tell full from empty.
module vec_log_fifo
  import vec_log_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = REC_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level = wptr_q - rptr_q;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Empty FIFO shows zero rather than stale memory.
  assign dout = empty ? '0 : mem[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && do_push) mem[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vec_logger.sv
// Captures applied mux vectors, compares y against expected,
// queues packed records and keeps saturating pass/fail counters.
module vec_logger
  import vec_log_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   cap_valid,
  input  logic [3:0]             cap_i,
  input  logic [1:0]             cap_s,
  input  logic                   cap_y,
  input  logic                   cap_exp,
  output logic                   out_valid,
  output logic [REC_W-1:0]       out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       vec_count,
  output logic [CNT_W-1:0]       err_count,
  output logic                   ovf
);

  logic             err;
  logic             push, pop;
  logic             full, empty;
  logic             drop;
  logic [REC_W-1:0] rec;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             ovf_q, ovf_d;

  assign err  = cap_y ^ cap_exp;
  assign rec  = pack_rec(err, cap_i, cap_s, cap_y);
  assign push = cap_valid && !clr;
  assign pop  = out_ready && !clr;
  assign drop = push && full && !(pop && !empty);

  vec_log_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr),
    .push  (push),
    .pop   (pop),
    .din   (rec),
    .dout  (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign out_valid = !empty;

  always_comb begin
    vec_d = vec_q;
    err_d = err_q;
    ovf_d = ovf_q;
    if (clr) begin
      vec_d = '0;
      err_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (push && vec_q != '1)        vec_d = vec_q + CNT_W'(1);
      if (push && err && err_q != '1) err_d = err_q + CNT_W'(1);
      if (drop)                       ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
      err_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vec_q <= vec_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end

  assign vec_count = vec_q;
  assign err_count = err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_vec_logger.sv
// Directed bench for vec_logger: capture, compare, FIFO fill/drain,
// overflow, clear, async reset and counter saturation.
module tb_vec_logger;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        cap_valid;
  logic [3:0]  cap_i;
  logic [1:0]  cap_s;
  logic        cap_y;
  logic        cap_exp;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [3:0]  level;
  logic [15:0] vec_count;
  logic [15:0] err_count;
  logic        ovf;

  logic        s_valid;
  logic [7:0]  s_data;
  logic [3:0]  s_level;
  logic [3:0]  s_vec;
  logic [3:0]  s_err;
  logic        s_ovf;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  vec_logger #(.DEPTH(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .cap_valid (cap_valid),
    .cap_i     (cap_i),
    .cap_s     (cap_s),
    .cap_y     (cap_y),
    .cap_exp   (cap_exp),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .vec_count (vec_count),
    .err_count (err_count),
    .ovf       (ovf)
  );

  vec_logger #(.DEPTH(8), .CNT_W(4)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .cap_valid (cap_valid),
    .cap_i     (cap_i),
    .cap_s     (cap_s),
    .cap_y     (cap_y),
    .cap_exp   (cap_exp),
    .out_valid (s_valid),
    .out_data  (s_data),
    .out_ready (out_ready),
    .level     (s_level),
    .vec_count (s_vec),
    .err_count (s_err),
    .ovf       (s_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] i,
                       input logic [1:0] s, input logic y,
                       input logic e);
    cap_valid = v;
    cap_i     = i;
    cap_s     = s;
    cap_y     = y;
    cap_exp   = e;
  endtask

  function automatic logic [7:0] fill_rec(input int k);
    logic [3:0] kb;
    kb = k[3:0];
    return {1'b0, kb, kb[1:0], kb[0]};
  endfunction

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr = 1'b0;
    out_ready = 1'b0;
    drive(0, 4'h0, 2'b00, 0, 0);
    step();
    step();
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00)
      $display("FAIL reset_out: valid=%b data=%h want 0/00",
               out_valid, out_data);
    else passed++;
    total++;
    if (level !== 4'd0 || ovf !== 1'b0)
      $display("FAIL reset_lvl: level=%0d ovf=%b want 0/0", level, ovf);
    else passed++;
    total++;
    if (vec_count !== 16'd0 || err_count !== 16'd0)
      $display("FAIL reset_cnt: vec=%0d err=%0d want 0/0",
               vec_count, err_count);
    else passed++;
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_capture();
    out_ready = 1'b1;
    drive(1, 4'b1010, 2'b01, 1, 1);
    step();
    drive(0, 4'h0, 2'b00, 0, 0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h53)
      $display("FAIL cap_match: valid=%b data=%h want 1/53",
               out_valid, out_data);
    else passed++;
    total++;
    if (vec_count !== 16'd1 || err_count !== 16'd0)
      $display("FAIL cap_match_cnt: vec=%0d err=%0d want 1/0",
               vec_count, err_count);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b0 || level !== 4'd0)
      $display("FAIL cap_pop: valid=%b level=%0d want 0/0",
               out_valid, level);
    else passed++;
    drive(1, 4'b0001, 2'b00, 0, 1);
    step();
    drive(0, 4'h0, 2'b00, 0, 0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h88)
      $display("FAIL cap_mismatch: valid=%b data=%h want 1/88",
               out_valid, out_data);
    else passed++;
    total++;
    if (vec_count !== 16'd2 || err_count !== 16'd1)
      $display("FAIL cap_mismatch_cnt: vec=%0d err=%0d want 2/1",
               vec_count, err_count);
    else passed++;
    step();
  endtask

  task automatic test_overflow();
    pulse_clr();
    total++;
    if (vec_count !== 16'd0 || level !== 4'd0)
      $display("FAIL clr_basic: vec=%0d level=%0d want 0/0",
               vec_count, level);
    else passed++;
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive(1, k[3:0], k[1:0], k[0], k[0]);
      step();
    end
    drive(0, 4'h0, 2'b00, 0, 0);
    total++;
    if (level !== 4'd8 || ovf !== 1'b1)
      $display("FAIL ovf_fill: level=%0d ovf=%b want 8/1", level, ovf);
    else passed++;
    total++;
    if (vec_count !== 16'd9 || err_count !== 16'd0)
      $display("FAIL ovf_cnt: vec=%0d err=%0d want 9/0",
               vec_count, err_count);
    else passed++;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== fill_rec(k))
        $display("FAIL drain_%0d: valid=%b data=%h want 1/%h",
                 k, out_valid, out_data, fill_rec(k));
      else passed++;
      step();
    end
    total++;
    if (out_valid !== 1'b0 || level !== 4'd0)
      $display("FAIL drain_end: valid=%b level=%0d want 0/0",
               out_valid, level);
    else passed++;
  endtask

  task automatic test_full_pop();
    pulse_clr();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1, k[3:0], k[1:0], k[0], k[0]);
      step();
    end
    drive(1, 4'd9, 2'b01, 1, 1);
    out_ready = 1'b1;
    step();
    drive(0, 4'h0, 2'b00, 0, 0);
    out_ready = 1'b0;
    total++;
    if (level !== 4'd8 || ovf !== 1'b0)
      $display("FAIL full_pop: level=%0d ovf=%b want 8/0", level, ovf);
    else passed++;
    total++;
    if (out_data !== fill_rec(1))
      $display("FAIL full_pop_head: data=%h want %h",
               out_data, fill_rec(1));
    else passed++;
    step();
    total++;
    if (out_data !== fill_rec(1) || level !== 4'd8)
      $display("FAIL stall_hold: data=%h level=%0d want %h/8",
               out_data, level, fill_rec(1));
    else passed++;
  endtask

  task automatic test_clear_reset();
    clr = 1'b1;
    out_ready = 1'b1;
    drive(1, 4'hF, 2'b11, 0, 1);
    step();
    clr = 1'b0;
    out_ready = 1'b0;
    drive(0, 4'h0, 2'b00, 0, 0);
    total++;
    if (vec_count !== 16'd0 || err_count !== 16'd0)
      $display("FAIL clr_cap: vec=%0d err=%0d want 0/0",
               vec_count, err_count);
    else passed++;
    total++;
    if (out_valid !== 1'b0 || level !== 4'd0 || ovf !== 1'b0)
      $display("FAIL clr_fifo: valid=%b level=%0d ovf=%b want 0/0/0",
               out_valid, level, ovf);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      drive(1, k[3:0], k[1:0], k[0], k[0]);
      step();
    end
    drive(0, 4'h0, 2'b00, 0, 0);
    total++;
    if (level !== 4'd3 || out_valid !== 1'b1)
      $display("FAIL pre_rst: level=%0d valid=%b want 3/1",
               level, out_valid);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || level !== 4'd0 || vec_count !== 16'd0)
      $display("FAIL async_rst: valid=%b level=%0d vec=%0d want 0/0/0",
               out_valid, level, vec_count);
    else passed++;
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_saturation();
    pulse_clr();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(1, k[3:0], k[1:0], 1, 0);
      step();
    end
    total++;
    if (s_vec !== 4'd15 || s_err !== 4'd15)
      $display("FAIL sat_cnt: vec=%0d err=%0d want 15/15", s_vec, s_err);
    else passed++;
    total++;
    if (vec_count !== 16'd20 || err_count !== 16'd20)
      $display("FAIL wide_cnt: vec=%0d err=%0d want 20/20",
               vec_count, err_count);
    else passed++;
    for (int k = 0; k < 3; k++) step();
    drive(0, 4'h0, 2'b00, 0, 0);
    total++;
    if (s_vec !== 4'd15 || s_err !== 4'd15)
      $display("FAIL sat_hold: vec=%0d err=%0d want 15/15", s_vec, s_err);
    else passed++;
    total++;
    if (s_ovf !== 1'b0)
      $display("FAIL sat_ovf: ovf=%b want 0", s_ovf);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_overflow();
    test_full_pop();
    test_clear_reset();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
